// File: rtl/display_tx_queue_if.sv
// ---------------------------------------------------------------------------
// display_tx_queue_if
//   Bundles the CPU-side display-register signals and the terminal-side strobe
//   bus of the display transmit queue.
//
//   CPU side : cpu_wr, cpu_din, flush (into queue); dsp_busy, overflow,
//              q_level (out of queue)
//   Terminal : vga_address, vga_enable, vga_w_en, vga_din (out of queue)
//
//   master modport : the queue itself (drives status and terminal bus)
//   slave  modport : the surrounding system (CPU decode + terminal)
// ---------------------------------------------------------------------------
interface display_tx_queue_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  cpu_wr;
    logic [7:0]            cpu_din;
    logic                  flush;
    logic                  dsp_busy;
    logic                  overflow;
    logic [DEPTH_LOG2:0]   q_level;
    logic                  vga_address;
    logic                  vga_enable;
    logic                  vga_w_en;
    logic [7:0]            vga_din;

    modport master (
        input  cpu_wr, cpu_din, flush,
        output dsp_busy, overflow, q_level,
        output vga_address, vga_enable, vga_w_en, vga_din
    );

    modport slave (
        output cpu_wr, cpu_din, flush,
        input  dsp_busy, overflow, q_level,
        input  vga_address, vga_enable, vga_w_en, vga_din
    );
endinterface

// File: rtl/display_tx_queue.sv
// ---------------------------------------------------------------------------
// display_tx_queue
//   Buffers characters written by the CPU to the display register and replays
//   them to the text terminal one at a time using its strobe handshake
//   (enable+w_en high for STROBE_CYCLES, low for RELEASE_CYCLES, then an
//   optional GAP_CYCLES idle pause). dsp_busy reports a full queue so software
//   can poll instead of losing characters.
//
//   Ports:
//     clk14 : system clock, single domain
//     rst   : synchronous active-high reset
//     bus   : display_tx_queue_if.master (CPU write/flush in, status and
//             terminal strobe bus out)
// ---------------------------------------------------------------------------
module display_tx_queue #(
    parameter int DEPTH_LOG2     = 4,
    parameter int STROBE_CYCLES  = 2,
    parameter int RELEASE_CYCLES = 2,
    parameter int GAP_CYCLES     = 0
) (
    input  logic                   clk14,
    input  logic                   rst,
    display_tx_queue_if.master     bus
);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int CNT_W  = DEPTH_LOG2 + 1;
    localparam int MAX_SR = (STROBE_CYCLES > RELEASE_CYCLES) ? STROBE_CYCLES : RELEASE_CYCLES;
    localparam int MAX_T  = (MAX_SR > GAP_CYCLES) ? MAX_SR : GAP_CYCLES;
    localparam int TW_RAW = $clog2(MAX_T + 1);
    localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [TW-1:0]    T_STROBE  = TW'(STROBE_CYCLES - 1);
    localparam logic [TW-1:0]    T_RELEASE = TW'(RELEASE_CYCLES - 1);
    // Only loaded when GAP_CYCLES > 0; the guard keeps the constant in range.
    localparam logic [TW-1:0]    T_GAP     = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, STROBE, RELEASE, GAP} state_t;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q;

    state_t                state_q;
    logic [TW-1:0]         timer_q;
    logic                  addr_q;
    logic                  en_q;
    logic [7:0]            din_q;

    logic full, empty, pop, push;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    // The FSM pops in IDLE; flush suppresses the pop so nothing leaves the
    // queue while it is being emptied.
    assign pop   = (state_q == IDLE) && !empty && !bus.flush;
    // A full queue still accepts a write when a slot frees in the same cycle.
    assign push  = bus.cpu_wr && !bus.flush && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (!push && pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk14) begin
        if (push) mem_q[wr_ptr_q] <= bus.cpu_din;
    end

    always_ff @(posedge clk14) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (bus.flush)
                overflow_q <= 1'b0;
            else if (bus.cpu_wr && full && !pop)
                overflow_q <= 1'b1;
        end
    end

    // Transfer FSM; every terminal-facing output is a register here.
    always_ff @(posedge clk14) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            addr_q  <= 1'b1;
            en_q    <= 1'b0;
            din_q   <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        din_q   <= mem_q[rd_ptr_q];
                        addr_q  <= 1'b0;
                        en_q    <= 1'b1;
                        timer_q <= T_STROBE;
                        state_q <= STROBE;
                    end
                end
                STROBE: begin
                    // A flush cuts the strobe short so the terminal still sees
                    // a full release phase rather than a truncated handshake.
                    if (bus.flush || timer_q == '0) begin
                        en_q    <= 1'b0;
                        timer_q <= T_RELEASE;
                        state_q <= RELEASE;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                RELEASE: begin
                    if (timer_q == '0) begin
                        addr_q <= 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state_q <= IDLE;
                        end else begin
                            timer_q <= T_GAP;
                            state_q <= GAP;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                GAP: begin
                    if (timer_q == '0) state_q <= IDLE;
                    else               timer_q <= timer_q - TW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dsp_busy    = full;
    assign bus.overflow    = overflow_q;
    assign bus.q_level     = count_q;
    assign bus.vga_address = addr_q;
    assign bus.vga_enable  = en_q;
    assign bus.vga_w_en    = en_q;
    assign bus.vga_din     = din_q;
endmodule

// File: tb/tb_display_tx_queue.sv
// ---------------------------------------------------------------------------
// tb_display_tx_queue
//   Bench for display_tx_queue. dut1 uses the default timing (no gap), dut2
//   adds GAP_CYCLES=3. Characters are pushed to a per-DUT scoreboard when the
//   write is driven and popped on each rising edge of vga_enable.
// ---------------------------------------------------------------------------
module tb_display_tx_queue;
    logic clk14 = 1'b0;
    always #5 clk14 = ~clk14;

    logic rst, rst2;

    display_tx_queue_if #(.DEPTH_LOG2(4)) bus1 ();
    display_tx_queue_if #(.DEPTH_LOG2(4)) bus2 ();

    display_tx_queue #(.DEPTH_LOG2(4), .STROBE_CYCLES(2), .RELEASE_CYCLES(2), .GAP_CYCLES(0))
        dut1 (.clk14(clk14), .rst(rst), .bus(bus1));
    display_tx_queue #(.DEPTH_LOG2(4), .STROBE_CYCLES(2), .RELEASE_CYCLES(2), .GAP_CYCLES(3))
        dut2 (.clk14(clk14), .rst(rst2), .bus(bus2));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] sb1[$];
    logic [7:0] sb2[$];
    int         rise2[$];
    logic       prev_en1 = 1'b0;
    logic       prev_en2 = 1'b0;
    logic [7:0] e1, e2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk14) cyc++;

    // Output monitors sample on the falling edge, away from the active edge.
    always @(negedge clk14) begin
        if (bus1.vga_enable && !prev_en1) begin
            if (sb1.size() == 0) begin
                chk("dut1_unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e1 = sb1.pop_front();
                chk("dut1_vga_din", bus1.vga_din, e1);
                chk("dut1_addr_at_strobe", bus1.vga_address, 0);
                chk("dut1_w_en_at_strobe", bus1.vga_w_en, 1);
            end
        end
        prev_en1 = bus1.vga_enable;
    end

    always @(negedge clk14) begin
        if (bus2.vga_enable && !prev_en2) begin
            rise2.push_back(cyc);
            if (sb2.size() == 0) begin
                chk("dut2_unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e2 = sb2.pop_front();
                chk("dut2_vga_din", bus2.vga_din, e2);
            end
        end
        prev_en2 = bus2.vga_enable;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk14);
            #1;
        end
    endtask

    task automatic wr1(input logic [7:0] b, input bit expect_out);
        bus1.cpu_wr  = 1'b1;
        bus1.cpu_din = b;
        if (expect_out) sb1.push_back(b);
        tick(1);
        bus1.cpu_wr = 1'b0;
    endtask

    task automatic wr2(input logic [7:0] b);
        bus2.cpu_wr  = 1'b1;
        bus2.cpu_din = b;
        sb2.push_back(b);
        tick(1);
        bus2.cpu_wr = 1'b0;
    endtask

    task automatic drain1(input string tag, input int max_cyc);
        int k = 0;
        while (sb1.size() != 0 && k < max_cyc) begin
            tick(1);
            k++;
        end
        chk(tag, sb1.size(), 0);
        tick(6);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        bus1.cpu_wr = 1'b0; bus1.cpu_din = 8'h00; bus1.flush = 1'b0;
        bus2.cpu_wr = 1'b0; bus2.cpu_din = 8'h00; bus2.flush = 1'b0;
        tick(3);

        // Reset state
        chk("rst_address", bus1.vga_address, 1);
        chk("rst_enable", bus1.vga_enable, 0);
        chk("rst_w_en", bus1.vga_w_en, 0);
        chk("rst_busy", bus1.dsp_busy, 0);
        chk("rst_overflow", bus1.overflow, 0);
        chk("rst_level", bus1.q_level, 0);
        chk("rst_din", bus1.vga_din, 8'h00);
        rst = 1'b0; rst2 = 1'b0;
        tick(2);

        // Single character handshake timing
        wr1(8'hC1, 1'b1);
        chk("single_t0_enable", bus1.vga_enable, 0);
        chk("single_t0_level", bus1.q_level, 1);
        tick(1);
        chk("single_t1_enable", bus1.vga_enable, 1);
        chk("single_t1_w_en", bus1.vga_w_en, 1);
        chk("single_t1_din", bus1.vga_din, 8'hC1);
        chk("single_t1_address", bus1.vga_address, 0);
        chk("single_t1_level", bus1.q_level, 0);
        tick(1);
        chk("single_t2_enable", bus1.vga_enable, 1);
        tick(1);
        chk("single_t3_enable", bus1.vga_enable, 0);
        chk("single_t3_address", bus1.vga_address, 0);
        tick(1);
        chk("single_t4_enable", bus1.vga_enable, 0);
        chk("single_t4_address", bus1.vga_address, 0);
        tick(1);
        chk("single_t5_address", bus1.vga_address, 1);
        chk("single_t5_din_stable", bus1.vga_din, 8'hC1);
        tick(2);

        // Burst: pops land every 5 cycles, so 20 writes fill the queue
        // and the 21st (no pop that cycle) is dropped.
        for (int i = 0; i < 21; i++) begin
            wr1(8'h10 + 8'(i), i < 20);
            if (i == 19) begin
                chk("burst_full_level", bus1.q_level, 16);
                chk("burst_full_busy", bus1.dsp_busy, 1);
                chk("burst_full_no_ovf", bus1.overflow, 0);
            end
        end
        chk("burst_drop_level", bus1.q_level, 16);
        chk("burst_drop_busy", bus1.dsp_busy, 1);
        chk("burst_drop_ovf", bus1.overflow, 1);
        drain1("burst_drain_timeout", 400);
        chk("burst_after_level", bus1.q_level, 0);
        chk("burst_after_busy", bus1.dsp_busy, 0);
        chk("burst_ovf_sticky", bus1.overflow, 1);

        // Flush clears the sticky overflow
        bus1.flush = 1'b1;
        tick(1);
        bus1.flush = 1'b0;
        chk("flush_clears_ovf", bus1.overflow, 0);
        tick(2);

        // Full queue plus write on the pop cycle
        for (int i = 0; i < 20; i++) wr1(8'h40 + 8'(i), 1'b1);
        chk("fullpop_pre_level", bus1.q_level, 16);
        tick(1);
        chk("fullpop_hold_level", bus1.q_level, 16);
        wr1(8'h8D, 1'b1);
        chk("fullpop_level", bus1.q_level, 16);
        chk("fullpop_ovf", bus1.overflow, 0);
        drain1("fullpop_drain_timeout", 400);
        chk("fullpop_after_level", bus1.q_level, 0);

        // Flush during STROBE with 5 queued; a write alongside flush is ignored
        for (int i = 0; i < 7; i++) wr1(8'h60 + 8'(i), 1'b1);
        chk("flush_pre_level", bus1.q_level, 5);
        chk("flush_pre_enable", bus1.vga_enable, 1);
        bus1.flush   = 1'b1;
        bus1.cpu_wr  = 1'b1;
        bus1.cpu_din = 8'h77;
        tick(1);
        bus1.flush  = 1'b0;
        bus1.cpu_wr = 1'b0;
        sb1.delete();
        chk("flush_enable", bus1.vga_enable, 0);
        chk("flush_w_en", bus1.vga_w_en, 0);
        chk("flush_level", bus1.q_level, 0);
        chk("flush_addr_held", bus1.vga_address, 0);
        tick(2);
        chk("flush_addr_back", bus1.vga_address, 1);
        tick(20);
        chk("flush_no_more_strobes", bus1.vga_enable, 0);

        // GAP_CYCLES=3: strobe period is 2+2+3+1 = 8 cycles
        wr2(8'hA1);
        wr2(8'hA2);
        begin
            int k = 0;
            while (rise2.size() < 2 && k < 40) begin
                tick(1);
                k++;
            end
        end
        if (rise2.size() >= 2) chk("gap_period", rise2[1] - rise2[0], 8);
        else                   chk("gap_period_timeout", rise2.size(), 2);
        tick(8);

        // Reset in the middle of a strobe drops enable on the next edge
        wr2(8'hB5);
        tick(1);
        chk("midrst_pre_enable", bus2.vga_enable, 1);
        rst2 = 1'b1;
        tick(1);
        rst2 = 1'b0;
        chk("midrst_enable", bus2.vga_enable, 0);
        chk("midrst_w_en", bus2.vga_w_en, 0);
        chk("midrst_address", bus2.vga_address, 1);
        chk("midrst_din", bus2.vga_din, 8'h00);
        chk("midrst_level", bus2.q_level, 0);
        tick(10);
        chk("dut2_all_emitted", sb2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
